// File: rtl/cgra_config_sequencer.sv
// CGRA configuration sequencer: streams config entries into the array one per cycle,
// then runs execution for a programmed cycle count while tracking the active context.
module cgra_config_sequencer #(
    parameter int PE_ROW_SIZE             = 4,
    parameter int PE_ROW_BIT_LENGTH       = $clog2(PE_ROW_SIZE),
    parameter int PE_COLUMN_SIZE          = 4,
    parameter int PE_COLUMN_BIT_LENGTH    = $clog2(PE_COLUMN_SIZE),
    parameter int CONTEXT_SIZE            = 16,
    parameter int CONTEXT_SIZE_BIT_LENGTH = $clog2(CONTEXT_SIZE),
    parameter int INPUT_NUM_BIT_LENGTH    = 3,
    parameter int OPERATION_BIT_LENGTH    = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int CYCLE_WIDTH             = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cmd_start,
    input  logic                               cmd_stop,
    input  logic [CYCLE_WIDTH-1:0]             cmd_num_entries,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cmd_context_max_id,
    input  logic [CYCLE_WIDTH-1:0]             cmd_exec_cycles,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [PE_ROW_BIT_LENGTH-1:0]       cfg_row,
    input  logic [PE_COLUMN_BIT_LENGTH-1:0]    cfg_col,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_ctx,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_in1,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_in2,
    input  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op,
    input  logic [DATA_WIDTH-1:0]              cfg_const,
    output logic [PE_ROW_BIT_LENGTH-1:0]       config_PE_row_index,
    output logic [PE_COLUMN_BIT_LENGTH-1:0]    config_PE_column_index,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic                               write_config_data,
    output logic                               start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cur_context,
    output logic [CYCLE_WIDTH-1:0]             iteration_count,
    output logic                               busy,
    output logic                               done,
    output logic                               aborted,
    output logic                               cfg_error
);

    typedef enum logic [1:0] {StIdle, StLoad, StExec, StDone} state_e;

    state_e                             r_state;
    state_e                             w_state_next;
    logic [CYCLE_WIDTH-1:0]             r_num_entries;
    logic [CYCLE_WIDTH-1:0]             r_exec_cycles;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_ctx_max;
    logic [CYCLE_WIDTH-1:0]             r_entry_cnt;
    logic [CYCLE_WIDTH-1:0]             r_cycle_cnt;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_cur_ctx;
    logic [CYCLE_WIDTH-1:0]             r_iter;
    logic                               r_cfg_error;
    logic                               r_aborted;
    logic                               r_write;
    logic [PE_ROW_BIT_LENGTH-1:0]       r_row;
    logic [PE_COLUMN_BIT_LENGTH-1:0]    r_col;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_idx;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    r_in1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    r_in2;
    logic [OPERATION_BIT_LENGTH-1:0]    r_op;
    logic [DATA_WIDTH-1:0]              r_const;

    logic w_accept;
    logic w_in_range;
    logic w_last_beat;
    logic w_exec_term;

    assign w_accept    = cfg_valid && (r_state == StLoad);
    // Widen to int so the range test stays meaningful when the index fields are oversized.
    assign w_in_range  = (int'(cfg_row) < PE_ROW_SIZE) && (int'(cfg_col) < PE_COLUMN_SIZE) &&
                         (cfg_ctx <= r_ctx_max);
    assign w_last_beat = (r_entry_cnt == r_num_entries - CYCLE_WIDTH'(1));
    assign w_exec_term = (r_exec_cycles != '0) && (r_cycle_cnt == r_exec_cycles);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cfg_ready    = 1'b0;
        start_exec   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        aborted      = 1'b0;
        unique case (r_state)
            StIdle: begin
                busy = 1'b0;
                if (cmd_start) begin
                    w_state_next = (cmd_num_entries != '0) ? StLoad : StExec;
                end
            end
            StLoad: begin
                cfg_ready = 1'b1;
                if (cmd_stop) begin
                    w_state_next = StDone;
                end else if (w_accept && w_last_beat) begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                start_exec = 1'b1;
                if (cmd_stop || w_exec_term) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                done         = 1'b1;
                aborted      = r_aborted;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_num_entries <= '0;
            r_exec_cycles <= '0;
            r_ctx_max     <= '0;
            r_entry_cnt   <= '0;
            r_cycle_cnt   <= '0;
            r_cur_ctx     <= '0;
            r_iter        <= '0;
            r_cfg_error   <= 1'b0;
            r_aborted     <= 1'b0;
            r_write       <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_idx         <= '0;
            r_in1         <= '0;
            r_in2         <= '0;
            r_op          <= '0;
            r_const       <= '0;
        end else begin
            r_write <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (cmd_start) begin
                        r_num_entries <= cmd_num_entries;
                        r_exec_cycles <= cmd_exec_cycles;
                        r_ctx_max     <= cmd_context_max_id;
                        r_entry_cnt   <= '0;
                        r_cycle_cnt   <= CYCLE_WIDTH'(1);
                        r_cur_ctx     <= '0;
                        r_iter        <= '0;
                        r_cfg_error   <= 1'b0;
                        r_aborted     <= 1'b0;
                    end
                end
                StLoad: begin
                    if (w_accept) begin
                        r_row       <= cfg_row;
                        r_col       <= cfg_col;
                        r_idx       <= cfg_ctx;
                        r_in1       <= cfg_in1;
                        r_in2       <= cfg_in2;
                        r_op        <= cfg_op;
                        r_const     <= cfg_const;
                        r_write     <= w_in_range;
                        r_entry_cnt <= r_entry_cnt + 1'b1;
                        if (!w_in_range) begin
                            r_cfg_error <= 1'b1;
                        end
                    end
                    if (cmd_stop) begin
                        r_aborted <= 1'b1;
                    end
                end
                StExec: begin
                    if (r_cycle_cnt != '1) begin
                        r_cycle_cnt <= r_cycle_cnt + 1'b1;
                    end
                    if (r_cur_ctx == r_ctx_max) begin
                        r_cur_ctx <= '0;
                        if (r_iter != '1) begin
                            r_iter <= r_iter + 1'b1;
                        end
                    end else begin
                        r_cur_ctx <= r_cur_ctx + 1'b1;
                    end
                    if (cmd_stop) begin
                        r_aborted <= 1'b1;
                    end
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign config_PE_row_index     = r_row;
    assign config_PE_column_index  = r_col;
    assign config_index            = r_idx;
    assign config_input_PE_index_1 = r_in1;
    assign config_input_PE_index_2 = r_in2;
    assign config_op               = r_op;
    assign config_const_data       = r_const;
    assign write_config_data       = r_write;
    assign mapping_context_max_id  = r_ctx_max;
    assign cur_context             = r_cur_ctx;
    assign iteration_count         = r_iter;
    assign cfg_error               = r_cfg_error;

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Scoreboard bench for cgra_config_sequencer: the driver queues expected strobes, contexts and
// completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_cgra_config_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_start, cmd_stop;
    logic [31:0] cmd_num_entries, cmd_exec_cycles;
    logic [3:0]  cmd_context_max_id;
    logic        cfg_valid, cfg_ready;
    logic [1:0]  cfg_row, cfg_col;
    logic [3:0]  cfg_ctx;
    logic [2:0]  cfg_in1, cfg_in2;
    logic [3:0]  cfg_op;
    logic [31:0] cfg_const;
    logic [1:0]  config_PE_row_index, config_PE_column_index;
    logic [3:0]  config_index;
    logic [2:0]  config_input_PE_index_1, config_input_PE_index_2;
    logic [3:0]  config_op;
    logic [31:0] config_const_data;
    logic        write_config_data, start_exec;
    logic [3:0]  mapping_context_max_id, cur_context;
    logic [31:0] iteration_count;
    logic        busy, done, aborted, cfg_error;

    always #5 clk = ~clk;

    cgra_config_sequencer dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .cmd_start               (cmd_start),
        .cmd_stop                (cmd_stop),
        .cmd_num_entries         (cmd_num_entries),
        .cmd_context_max_id      (cmd_context_max_id),
        .cmd_exec_cycles         (cmd_exec_cycles),
        .cfg_valid               (cfg_valid),
        .cfg_ready               (cfg_ready),
        .cfg_row                 (cfg_row),
        .cfg_col                 (cfg_col),
        .cfg_ctx                 (cfg_ctx),
        .cfg_in1                 (cfg_in1),
        .cfg_in2                 (cfg_in2),
        .cfg_op                  (cfg_op),
        .cfg_const               (cfg_const),
        .config_PE_row_index     (config_PE_row_index),
        .config_PE_column_index  (config_PE_column_index),
        .config_index            (config_index),
        .config_input_PE_index_1 (config_input_PE_index_1),
        .config_input_PE_index_2 (config_input_PE_index_2),
        .config_op               (config_op),
        .config_const_data       (config_const_data),
        .write_config_data       (write_config_data),
        .start_exec              (start_exec),
        .mapping_context_max_id  (mapping_context_max_id),
        .cur_context             (cur_context),
        .iteration_count         (iteration_count),
        .busy                    (busy),
        .done                    (done),
        .aborted                 (aborted),
        .cfg_error               (cfg_error)
    );

    typedef struct {
        int unsigned due;
        logic [49:0] fields;
    } wexp_t;

    typedef struct packed {
        logic        ab;
        logic [31:0] iter;
        logic        err;
    } dexp_t;

    wexp_t       wq[$];
    logic [3:0]  cq[$];
    dexp_t       dq[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    wexp_t       m_w;
    dexp_t       m_d;
    logic [3:0]  m_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT-presented event must match the head of its queue.
    always @(negedge clk) begin
        if (write_config_data === 1'b1) begin
            chk("strobe_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                m_w = wq.pop_front();
                chk("strobe_latency", 64'(cyc), 64'(m_w.due));
                chk("strobe_fields", 64'({config_PE_row_index, config_PE_column_index,
                    config_index, config_input_PE_index_1, config_input_PE_index_2, config_op,
                    config_const_data}), 64'(m_w.fields));
            end
        end
        if (start_exec === 1'b1) begin
            chk("exec_expected", 64'(cq.size() != 0), 64'd1);
            if (cq.size() != 0) begin
                m_c = cq.pop_front();
                chk("cur_context", 64'(cur_context), 64'(m_c));
            end
        end
        if (done === 1'b1) begin
            chk("done_expected", 64'(dq.size() != 0), 64'd1);
            if (dq.size() != 0) begin
                m_d = dq.pop_front();
                chk("done_status", 64'({aborted, iteration_count, cfg_error}), 64'(m_d));
            end
        end
    end

    task automatic start_job(input logic [31:0] num, input logic [3:0] maxid,
                             input logic [31:0] execc, input logic stop);
        cmd_num_entries    = num;
        cmd_context_max_id = maxid;
        cmd_exec_cycles    = execc;
        cmd_start          = 1'b1;
        cmd_stop           = stop;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
    endtask

    task automatic send_beat(input logic [1:0] r, input logic [1:0] c, input logic [3:0] x,
                             input logic [2:0] i1, input logic [2:0] i2, input logic [3:0] op,
                             input logic [31:0] d, input logic good, input logic stop);
        logic got;
        got       = 1'b0;
        cfg_valid = 1'b1;
        cfg_row   = r;
        cfg_col   = c;
        cfg_ctx   = x;
        cfg_in1   = i1;
        cfg_in2   = i2;
        cfg_op    = op;
        cfg_const = d;
        cmd_stop  = stop;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cfg_ready === 1'b1) got = 1'b1;
        end
        chk("beat_accepted", 64'(got), 64'd1);
        if (got && good) wq.push_back('{due: cyc + 1, fields: {r, c, x, i1, i2, op, d}});
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cmd_stop  = 1'b0;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            if (busy === 1'b0) idle = 1'b1;
        end
        chk("job_completes", 64'(idle), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        cmd_start = 1'b0; cmd_stop = 1'b0;
        cmd_num_entries = '0; cmd_exec_cycles = '0; cmd_context_max_id = '0;
        cfg_valid = 1'b0; cfg_row = '0; cfg_col = '0; cfg_ctx = '0;
        cfg_in1 = '0; cfg_in2 = '0; cfg_op = '0; cfg_const = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("rst_start_exec", 64'(start_exec), 64'd0);
        chk("rst_write", 64'(write_config_data), 64'd0);
        chk("rst_iter", 64'(iteration_count), 64'd0);
        chk("rst_cfg_error", 64'(cfg_error), 64'd0);

        // cmd_stop alone in IDLE is ignored
        @(posedge clk); #1 cmd_stop = 1'b1;
        @(posedge clk); #1 cmd_stop = 1'b0;
        @(negedge clk);
        chk("idle_stop_busy", 64'(busy), 64'd0);
        chk("idle_stop_done", 64'(done), 64'd0);

        // Three back-to-back entries, then 2 exec cycles
        dq.push_back('{ab: 1'b0, iter: 32'd0, err: 1'b0});
        cq.push_back(4'd0); cq.push_back(4'd1);
        @(posedge clk); #1;
        start_job(32'd3, 4'd3, 32'd2, 1'b0);
        send_beat(2'd0, 2'd1, 4'd2, 3'd1, 3'd2, 4'd3, 32'hA5A5_0001, 1'b1, 1'b0);
        send_beat(2'd3, 2'd3, 4'd0, 3'd4, 3'd5, 4'd6, 32'h0000_1234, 1'b1, 1'b0);
        send_beat(2'd1, 2'd0, 4'd1, 3'd7, 3'd0, 4'd9, 32'hDEAD_BEEF, 1'b1, 1'b0);
        wait_idle();

        // Second entry exceeds max context id: dropped, error flagged, exec still runs
        dq.push_back('{ab: 1'b0, iter: 32'd1, err: 1'b1});
        cq.push_back(4'd0); cq.push_back(4'd1); cq.push_back(4'd0);
        start_job(32'd2, 4'd1, 32'd3, 1'b0);
        send_beat(2'd0, 2'd0, 4'd1, 3'd3, 3'd3, 4'd1, 32'h0000_0042, 1'b1, 1'b0);
        send_beat(2'd1, 2'd1, 4'd3, 3'd2, 3'd1, 4'd2, 32'h0000_0099, 1'b0, 1'b0);
        wait_idle();
        chk("err_sticky", 64'(cfg_error), 64'd1);
        chk("err_iter_hold", 64'(iteration_count), 64'd1);
        chk("err_max_id", 64'(mapping_context_max_id), 64'd1);

        // No entries, 10 exec cycles; a stray cmd_start mid-run has no effect
        dq.push_back('{ab: 1'b0, iter: 32'd2, err: 1'b0});
        for (int i = 0; i < 10; i++) cq.push_back(4'(i % 4));
        start_job(32'd0, 4'd3, 32'd10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cmd_start = 1'b1; cmd_num_entries = 32'd5; cmd_exec_cycles = 32'd1;
        @(posedge clk); #1 cmd_start = 1'b0;
        wait_idle();
        chk("run10_iter_hold", 64'(iteration_count), 64'd2);
        chk("run10_ctx_hold", 64'(cur_context), 64'd2);
        chk("run10_err_cleared", 64'(cfg_error), 64'd0);

        // Unbounded run stopped during exec cycle 7
        dq.push_back('{ab: 1'b1, iter: 32'd2, err: 1'b0});
        for (int i = 0; i < 7; i++) cq.push_back(4'(i % 3));
        start_job(32'd0, 4'd2, 32'd0, 1'b0);
        repeat (6) @(posedge clk);
        #1 cmd_stop = 1'b1;
        @(posedge clk); #1 cmd_stop = 1'b0;
        wait_idle();

        // Start with stop in IDLE (start wins), gaps in cfg_valid, stop on an accepted beat
        dq.push_back('{ab: 1'b1, iter: 32'd0, err: 1'b0});
        start_job(32'd4, 4'd3, 32'd5, 1'b1);
        send_beat(2'd2, 2'd1, 4'd3, 3'd1, 3'd1, 4'd4, 32'h1111_2222, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send_beat(2'd1, 2'd2, 4'd0, 3'd6, 3'd5, 4'd7, 32'h3333_4444, 1'b1, 1'b0);
        @(posedge clk); #1;
        send_beat(2'd3, 2'd0, 4'd2, 3'd2, 3'd3, 4'd8, 32'h5555_6666, 1'b1, 1'b1);
        wait_idle();
        chk("stopload_iter", 64'(iteration_count), 64'd0);

        // Reset in the middle of an unbounded run
        for (int i = 0; i < 4; i++) cq.push_back(4'(i % 2));
        start_job(32'd0, 4'd1, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_start_exec", 64'(start_exec), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_iter", 64'(iteration_count), 64'd0);
        chk("midrst_ctx", 64'(cur_context), 64'd0);
        chk("midrst_max_id", 64'(mapping_context_max_id), 64'd0);
        repeat (3) @(negedge clk);

        chk("strobes_drained", 64'(wq.size()), 64'd0);
        chk("contexts_drained", 64'(cq.size()), 64'd0);
        chk("dones_drained", 64'(dq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cgra_config_sequencer.md
Name: cgra_config_sequencer

Overview:
- Controller in front of the CGRA array.
- Accepts a stream of configuration entries and writes them into the array one entry per cycle through the CGRA config-load interface.
- Then runs execution for a programmed number of cycles while tracking the current context index, and reports completion.
- Sits between the host/testbench command interface and the CGRA top.

Parameters:
- PE_ROW_SIZE, 4, array rows; PE_ROW_BIT_LENGTH = $clog2(PE_ROW_SIZE)
- PE_COLUMN_SIZE, 4, array columns; PE_COLUMN_BIT_LENGTH = $clog2(PE_COLUMN_SIZE)
- CONTEXT_SIZE, 16, contexts per PE; CONTEXT_SIZE_BIT_LENGTH = $clog2(CONTEXT_SIZE)
- INPUT_NUM_BIT_LENGTH, 3, PE input-select width
- OPERATION_BIT_LENGTH, 4, opcode width
- DATA_WIDTH, 32, constant width
- CYCLE_WIDTH, 32, execution-cycle and entry-count width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  synchronous active-low reset
- cmd_start  in  1  start a load+run job; sampled in IDLE only
- cmd_stop  in  1  abort the current job
- cmd_num_entries  in  CYCLE_WIDTH  number of config entries to load
- cmd_context_max_id  in  CONTEXT_SIZE_BIT_LENGTH  last context id
- cmd_exec_cycles  in  CYCLE_WIDTH  execution cycles; 0 = run until cmd_stop
- cfg_valid  in  1  config entry valid
- cfg_ready  out  1  sequencer accepts the entry
- cfg_row  in  PE_ROW_BIT_LENGTH  target PE row
- cfg_col  in  PE_COLUMN_BIT_LENGTH  target PE column
- cfg_ctx  in  CONTEXT_SIZE_BIT_LENGTH  target context
- cfg_in1, cfg_in2  in  INPUT_NUM_BIT_LENGTH  input selects
- cfg_op  in  OPERATION_BIT_LENGTH  opcode
- cfg_const  in  DATA_WIDTH  constant
- config_PE_row_index, config_PE_column_index, config_index, config_input_PE_index_1, config_input_PE_index_2, config_op, config_const_data  out  matching widths  registered config fields to the CGRA
- write_config_data  out  1  one-cycle write strobe to the CGRA
- start_exec  out  1  execution enable to the CGRA
- mapping_context_max_id  out  CONTEXT_SIZE_BIT_LENGTH  latched cmd_context_max_id
- cur_context  out  CONTEXT_SIZE_BIT_LENGTH  context currently executing
- iteration_count  out  CYCLE_WIDTH  completed context wraps
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- aborted  out  1  held with done when the job ended via cmd_stop
- cfg_error  out  1  sticky: an out-of-range entry was dropped

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State goes to IDLE.
  - All outputs and counters go to 0, including cfg_error.
  - Reset applied mid-LOAD or mid-EXEC aborts immediately; no done pulse.
- States: IDLE, LOAD, EXEC, DONE.
- IDLE:
  - cfg_ready=0.
  - cmd_start=1: latch cmd_num_entries, cmd_exec_cycles, cmd_context_max_id; clear cfg_error, iteration_count, cur_context.
  - Next state is LOAD if the entry count is >0, else EXEC.
- LOAD:
  - cfg_ready=1 combinationally.
  - On each accepted beat (cfg_valid & cfg_ready), register all fields onto the config_* outputs.
  - Pulse write_config_data for exactly one cycle, the cycle after acceptance (1-cycle latency).
  - Back-to-back beats give back-to-back strobes.
  - Out-of-range beat (row >= PE_ROW_SIZE, col >= PE_COLUMN_SIZE, or ctx > latched max id): consumed, no strobe, cfg_error set, still counted.
  - When the beat that makes the count equal the latched count is accepted, next state is EXEC. The final strobe coincides with the first EXEC cycle.
  - Config outputs hold their last value between beats.
- EXEC:
  - start_exec=1, registered: high in every EXEC cycle, low otherwise.
  - Cycle counter starts at 1 in the first EXEC cycle.
  - cur_context starts at 0 and increments each EXEC cycle.
  - On the cycle after cur_context == mapping_context_max_id, cur_context wraps to 0 and iteration_count increments.
  - When cmd_exec_cycles != 0 and the counter equals it, next state is DONE.
  - Counter and iteration_count saturate at all-ones.
- DONE:
  - done=1 for one cycle; start_exec=0.
  - Next state is IDLE.
  - iteration_count, cur_context and cfg_error hold until the next cmd_start.
- cmd_stop in LOAD or EXEC: next state is DONE and aborted=1 during DONE.
  - If a beat is accepted in the same cycle, that beat's strobe is still issued.
  - cmd_stop has priority over the exec-cycle terminal count.
- cmd_start while busy: ignored. cmd_stop in IDLE or DONE: ignored.
- Simultaneous cmd_start and cmd_stop in IDLE: start wins.

Test Plan:
- reset_n=0 for 2 cycles mid-EXEC → next cycle busy=0, start_exec=0, done=0, all counters 0.
- cmd_num_entries=3, cfg_valid held high, entries (r0,c1,ctx2), (r3,c3,ctx0), (r1,c0,ctx1) → write_config_data high for 3 consecutive cycles with matching row/col/index, one cycle after each acceptance.
- cmd_num_entries=2, cmd_context_max_id=1, second entry cfg_row=5 (PE_ROW_SIZE=4 with PE_ROW_BIT_LENGTH widened by test override) or ctx=3 → only 1 strobe, cfg_error=1, sequencer still enters EXEC.
- cmd_num_entries=0, cmd_exec_cycles=10, cmd_context_max_id=3:
  - start_exec high exactly 10 cycles.
  - cur_context sequence 0,1,2,3,0,1,2,3,0,1.
  - iteration_count=2 at done; done a single-cycle pulse, aborted=0.
- cmd_exec_cycles=0, cmd_stop asserted at EXEC cycle 7 → done=1 with aborted=1 next cycle, start_exec low from that cycle.
- cmd_start pulsed during EXEC → no effect on counters; gaps in cfg_valid during LOAD → strobes only for accepted beats.
